// File: rtl/a5_1_keystream_gen.sv
// A5/1 keystream generator: key/frame load, majority-clocked warm-up, then
// one keystream bit per accepted valid/ready beat.
module a5_1_keystream_gen #(
    parameter int KS_LEN = 228,
    parameter int WARMUP = 101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [21:0] frame,
    output logic        busy,
    output logic        ks_valid,
    input  logic        ks_ready,
    output logic        ks_bit,
    output logic        ks_last,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, LKEY, LFRM, WARM, KS} state_t;

    state_t      state;
    logic [18:0] r1;
    logic [21:0] r2;
    logic [22:0] r3;
    logic [63:0] key_q;
    logic [21:0] frame_q;
    logic [15:0] cnt;

    logic        fb1, fb2, fb3, inj, maj;
    logic [2:0]  trig, en;
    logic [18:0] r1_nx;
    logic [21:0] r2_nx;
    logic [22:0] r3_nx;

    assign fb1 = r1[13] ^ r1[16] ^ r1[17] ^ r1[18];
    assign fb2 = r2[20] ^ r2[21];
    assign fb3 = r3[7] ^ r3[20] ^ r3[21] ^ r3[22];

    // Majority stage: a register steps when its clocking bit agrees with the majority.
    assign maj  = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
    assign trig = {r1[8] == maj, r2[10] == maj, r3[10] == maj};

    // Shadow registers shift right during load, so bit 0 is always the next bit to inject.
    always_comb begin
        inj = 1'b0;
        en  = 3'b000;
        case (state)
            LKEY: begin inj = key_q[0];   en = 3'b111; end
            LFRM: begin inj = frame_q[0]; en = 3'b111; end
            WARM: en = trig;
            KS:   en = ks_ready ? trig : 3'b000;
            default: en = 3'b000;
        endcase
    end

    assign r1_nx  = {r1[17:0], fb1 ^ inj};
    assign r2_nx  = {r2[20:0], fb2 ^ inj};
    assign r3_nx  = {r3[21:0], fb3 ^ inj};
    assign ks_bit = r1[18] ^ r2[21] ^ r3[22];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            key_q    <= '0;
            frame_q  <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            ks_valid <= 1'b0;
            ks_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en[2]) r1 <= r1_nx;
            if (en[1]) r2 <= r2_nx;
            if (en[0]) r3 <= r3_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_q   <= key;
                        frame_q <= frame;
                        r1      <= '0;
                        r2      <= '0;
                        r3      <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= LKEY;
                    end
                end
                LKEY: begin
                    key_q <= key_q >> 1;
                    if (cnt == 16'd63) begin
                        cnt   <= '0;
                        state <= LFRM;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                LFRM: begin
                    frame_q <= frame_q >> 1;
                    if (cnt == 16'd21) begin
                        cnt   <= '0;
                        state <= WARM;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WARM: begin
                    if (cnt == 16'(WARMUP - 1)) begin
                        cnt      <= '0;
                        ks_valid <= 1'b1;
                        ks_last  <= (KS_LEN == 1);
                        state    <= KS;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                KS: begin
                    if (ks_ready) begin
                        if (cnt == 16'(KS_LEN - 1)) begin
                            ks_valid <= 1'b0;
                            ks_last  <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            cnt     <= cnt + 16'd1;
                            ks_last <= (cnt + 16'd1 == 16'(KS_LEN - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_a5_1_keystream_gen.sv
// Directed bench for a5_1_keystream_gen against the published A5/1 reference vector.
module tb_a5_1_keystream_gen;
    localparam logic [63:0]  KEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0]  FRAME = 22'h000134;
    localparam logic [119:0] AB    = 120'h534EAA582FE8151AB6E1855A728C00;
    localparam logic [119:0] BA    = 120'h24FD35A35D5FB6526D32F906DF1AC0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, ks_ready = 1'b1;
    logic [63:0] key = '0;
    logic [21:0] frame = '0;
    logic        busy, ks_valid, ks_bit, ks_last, done;

    logic        start1 = 1'b0, ks_ready1 = 1'b0;
    logic        busy1, ks_valid1, ks_bit1, ks_last1, done1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    a5_1_keystream_gen #(.KS_LEN(228), .WARMUP(101)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .frame(frame),
        .busy(busy), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_bit(ks_bit),
        .ks_last(ks_last), .done(done)
    );

    a5_1_keystream_gen #(.KS_LEN(1), .WARMUP(101)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .key(KEY), .frame(FRAME),
        .busy(busy1), .ks_valid(ks_valid1), .ks_ready(ks_ready1), .ks_bit(ks_bit1),
        .ks_last(ks_last1), .done(done1)
    );

    function automatic logic exp_bit(input int k);
        if (k < 114) return AB[119 - k];
        return BA[119 - (k - 114)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of cycle 1.
    task automatic pulse_start(input logic [63:0] k, input logic [21:0] f);
        start = 1'b1;
        key   = k;
        frame = f;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full session on the KS_LEN=228 instance. rst_at >= 0 resets at that bit.
    task automatic run_session(input bit rnd, input bit inject, input int rst_at);
        int   idx = 0;
        int   cyc = 1;
        bit   prev_stall = 1'b0;
        logic prev_bit = 1'b0;
        bit   rdy;
        bit   saw_done;
        pulse_start(KEY, FRAME);
        chk("busy_cycle1", busy, 1);
        chk("valid_cycle1", ks_valid, 0);
        while (!ks_valid && cyc < 400) begin
            if (inject && cyc == 70) begin
                start = 1'b1; key = ~KEY; frame = ~FRAME;
            end else begin
                start = 1'b0;
            end
            chk("busy_load", busy, 1);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("first_valid_cycle", cyc, 188);
        while (idx < 228 && cyc < 2000) begin
            if (rst_at >= 0 && idx == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_ks_busy", busy, 0);
                chk("rst_ks_valid", ks_valid, 0);
                chk("rst_ks_last", ks_last, 0);
                chk("rst_ks_done", done, 0);
                saw_done = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (done || ks_valid) saw_done = 1'b1;
                end
                chk("rst_ks_quiet", saw_done, 0);
                return;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) chk($sformatf("stall_stable%0d", idx), ks_bit, prev_bit);
            chk("valid_in_ks", ks_valid, 1);
            chk($sformatf("last%0d", idx), ks_last, (idx == 227));
            chk("no_early_done", done, 0);
            ks_ready = rdy;
            if (inject && idx == 20) begin
                start = 1'b1; key = 64'h0123456789ABCDEF; frame = 22'h3FFFFF;
            end else begin
                start = 1'b0;
            end
            if (rdy) begin
                chk($sformatf("bit%0d", idx), ks_bit, exp_bit(idx));
                if (idx == 227) chk("busy_last", busy, 1);
                idx++;
            end
            prev_stall = !rdy;
            prev_bit   = ks_bit;
            @(negedge clk);
            cyc++;
        end
        ks_ready = 1'b1;
        start    = 1'b0;
        chk("bits_accepted", idx, 228);
        chk("done_pulse", done, 1);
        chk("valid_after_last", ks_valid, 0);
        chk("last_after_last", ks_last, 0);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int  cyc;
        bit  flag;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_valid", ks_valid, 0);
        chk("reset_last", ks_last, 0);
        chk("reset_done", done, 0);
        chk("reset_bit", ks_bit, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Standard vector, ready held high.
        run_session(1'b0, 1'b0, -1);
        // Pseudo-random backpressure.
        run_session(1'b1, 1'b0, -1);
        // Start pulses with a different key during LFRM and KS are ignored.
        run_session(1'b0, 1'b1, -1);

        // Reset during warm-up.
        pulse_start(KEY, FRAME);
        repeat (99) @(negedge clk);
        chk("in_warm_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_warm_busy", busy, 0);
        chk("rst_warm_valid", ks_valid, 0);
        chk("rst_warm_last", ks_last, 0);
        chk("rst_warm_done", done, 0);
        flag = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (done || ks_valid || busy) flag = 1'b1;
        end
        chk("rst_warm_quiet", flag, 0);
        run_session(1'b0, 1'b0, -1);

        // Reset during KS at bit 50, then a clean session.
        run_session(1'b0, 1'b0, 50);
        run_session(1'b1, 1'b0, -1);

        // KS_LEN = 1 instance.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1;
        chk("k1_busy", busy1, 1);
        while (!ks_valid1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("k1_latency", cyc, 188);
        chk("k1_last", ks_last1, 1);
        chk("k1_bit", ks_bit1, exp_bit(0));
        @(negedge clk);
        chk("k1_stall_valid", ks_valid1, 1);
        chk("k1_stall_last", ks_last1, 1);
        chk("k1_stall_done", done1, 0);
        ks_ready1 = 1'b1;
        @(negedge clk);
        ks_ready1 = 1'b0;
        chk("k1_done", done1, 1);
        chk("k1_valid_off", ks_valid1, 0);
        @(negedge clk);
        chk("k1_done_single", done1, 0);
        chk("k1_idle", busy1, 0);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("k1_restart_busy", busy1, 1);
        cyc = 1;
        while (!ks_valid1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("k1_restart_latency", cyc, 188);
        chk("k1_restart_bit", ks_bit1, exp_bit(0));
        chk("k1_restart_last", ks_last1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/a5_1_keystream_gen.md
Name: a5_1_keystream_gen

Overview:
- A5/1 keystream generator for the image-encryption datapath.
- Holds the three A5/1 LFSRs: R1 (19 bits), R2 (22 bits) and R3 (23 bits).
- Drives the Majority stage with R1[8], R2[10] and R3[10], and uses its 3-bit trigger as the per-register clock enable.
- Sequences key load, frame load and warm-up, then streams keystream bits one at a time over a valid/ready handshake to the downstream XOR stage.

Parameters:
- KS_LEN, 228: keystream bits emitted per start; legal range 1..1023.
- WARMUP, 101: majority-clocked cycles with discarded output before the first bit. 101 gives standard A5/1 alignment: 100 discarded clocks, then clock-before-output.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a session; honoured only in IDLE.
- key  input  64  session key, sampled on accepted start. Bit i = key byte i/8, bit i%8; loaded LSB first.
- frame  input  22  frame number, sampled on accepted start; loaded LSB first.
- busy  output  1  high in every state except IDLE.
- ks_valid  output  1  keystream bit available (KS state only).
- ks_ready  input  1  consumer accepts ks_bit when high with ks_valid.
- ks_bit  output  1  R1[18]^R2[21]^R3[22], from the current register contents.
- ks_last  output  1  high with ks_valid on the final (KS_LEN-th) bit.
- done  output  1  one-cycle pulse the cycle after the last bit is accepted.

Behaviour:
- Reset values: R1, R2, R3, key/frame shadow registers and all counters = 0; state = IDLE; busy = ks_valid = ks_last = done = 0.
- Reset is synchronous and overrides every state: an in-progress session is abandoned with no done pulse.
- Feedback taps:
  - R1: 13^16^17^18.
  - R2: 20^21.
  - R3: 7^20^21^22.
- Shift rule: R <= {R[n-2:0], fb ^ inj}, where inj is the load bit in LOAD states and 0 otherwise.
- Majority hookup: Majority x = R1[8], y = R2[10], z = R3[10].
  - trigger[2] enables R1, trigger[1] enables R2, trigger[0] enables R3.
  - At least two registers move on every majority clock.
- State machine:
  - IDLE: on start, capture key/frame, clear R1–R3 and the counter, go to LKEY. start outside IDLE is ignored.
  - LKEY: 64 cycles. All three registers clock unconditionally with inj = key[cnt], cnt = 0..63. After cnt = 63, go to LFRM.
  - LFRM: 22 cycles. All three clock with inj = frame[cnt], cnt = 0..21. Then go to WARM.
  - WARM: WARMUP cycles, majority-clocked, output ignored. Then go to KS.
  - KS: ks_valid = 1.
    - On ks_valid & ks_ready: majority-clock once and increment the bit counter.
    - With ready low: registers hold and ks_bit stays stable.
    - ks_last = 1 when bit count = KS_LEN-1. Acceptance of that bit goes to IDLE with done = 1 for one cycle.
- Total latency from start to first ks_valid: 1 + 64 + 22 + WARMUP cycles (188 at defaults).
- Throughput: one bit per cycle while ks_ready is held high.
- Registers retain their contents in IDLE after done; a new start reloads from zero.

Test Plan:
- Standard vector: key = 64'hEFCDAB8967452312 (bytes 12 23 45 67 89 AB CD EF), frame = 22'h000134, ks_ready = 1 → the 228 bits, MSB first, match A→B 534EAA582FE8151AB6E1855A728C00 followed by B→A 24FD35A35D5FB6526D32F906DF1AC0; first 8 bits are 0,1,0,1,0,0,1,1.
- Latency: start pulse at cycle 0 → ks_valid first high at cycle 188. busy high from cycle 1 through the done cycle. done is a single pulse after the 228th accept, with ks_last high only on bit 228.
- Backpressure: same vector, ks_ready toggled pseudo-randomly → identical bit sequence. ks_bit is stable while ks_valid & !ks_ready, and no register changes on stalled cycles.
- Start while busy: second start with a different key during LFRM and again during KS → ignored; output still equals the standard vector.
- Reset mid-operation: assert rst for 1 cycle in WARM, then during KS bit 50 → all outputs 0 the next cycle, no done pulse. A following start reproduces the standard vector from bit 1.
- Parameter edge: KS_LEN = 1 → ks_last high with the first ks_valid, done the cycle after acceptance. Back-to-back start in the cycle after done is honoured.
